// File: rtl/encoder_rpm_meter.sv
// Quadrature encoder speed meter: counts decoded steps over a fixed gate window and
// emits a scaled, clamped, signed RPM sample once per window.
module encoder_rpm_meter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CLK_FREQ   = 27_000_000,
  parameter int unsigned GATE_HZ    = 100,
  parameter int unsigned RPM_MUL    = 291,
  parameter int unsigned RPM_SHIFT  = 6,
  parameter int unsigned RPM_MAX    = 1023
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enc_a,
  input  logic                  enc_b,
  input  logic                  dir_inv,
  output logic                  rpm_ready,
  output logic [DATA_WIDTH-1:0] rpm_data_o,
  output logic                  illegal_o
);

  localparam int unsigned GATE_CYC = CLK_FREQ / GATE_HZ;
  localparam int unsigned CNT_W    = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int unsigned PW       = 2 * DATA_WIDTH;

  localparam logic signed [DATA_WIDTH:0] ACC_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0] ACC_MIN = {2'b11, {(DATA_WIDTH-2){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0]       MUL_P   = PW'(RPM_MUL);
  localparam logic signed [PW-1:0]       MAX_P   = PW'(RPM_MAX);
  localparam logic signed [PW-1:0]       MIN_P   = -MAX_P;

  logic                         a_s1, a_s2, b_s1, b_s2, a_prev, b_prev;
  logic [1:0]                   prime_q;
  logic                         primed;
  logic [CNT_W-1:0]             gate_q;
  logic                         tick;
  logic signed [1:0]            step;
  logic                         illegal_d;
  logic signed [DATA_WIDTH-1:0] acc_q;
  logic signed [DATA_WIDTH:0]   acc_sum;
  logic signed [DATA_WIDTH-1:0] acc_sat;
  logic signed [PW-1:0]         prod_q;
  logic signed [PW-1:0]         shifted;
  logic                         v1_q;
  logic [DATA_WIDTH-1:0]        data_d;

  assign primed = (prime_q == 2'd3);
  assign tick   = (gate_q == CNT_W'(GATE_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_s1    <= 1'b0;
      a_s2    <= 1'b0;
      b_s1    <= 1'b0;
      b_s2    <= 1'b0;
      a_prev  <= 1'b0;
      b_prev  <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      a_s1    <= enc_a;
      a_s2    <= a_s1;
      b_s1    <= enc_b;
      b_s2    <= b_s1;
      a_prev  <= a_s2;
      b_prev  <= b_s2;
      if (!primed) prime_q <= prime_q + 2'd1;
    end
  end

  // Gray-code decode of {A,B}; A leading B counts up.
  always_comb begin
    step      = 2'sd0;
    illegal_d = 1'b0;
    case ({a_prev, b_prev, a_s2, b_s2})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step = 2'sd1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: step = -2'sd1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal_d = 1'b1;
      default: ;
    endcase
    if (!primed) begin
      step      = 2'sd0;
      illegal_d = 1'b0;
    end else if (dir_inv) begin
      step = -step;
    end
  end

  always_comb begin
    acc_sum = {acc_q[DATA_WIDTH-1], acc_q} + {{(DATA_WIDTH-1){step[1]}}, step};
    if (acc_sum > ACC_MAX)      acc_sat = ACC_MAX[DATA_WIDTH-1:0];
    else if (acc_sum < ACC_MIN) acc_sat = ACC_MIN[DATA_WIDTH-1:0];
    else                        acc_sat = acc_sum[DATA_WIDTH-1:0];
  end

  always_comb begin
    shifted = prod_q >>> RPM_SHIFT;
    if (shifted > MAX_P)      data_d = MAX_P[DATA_WIDTH-1:0];
    else if (shifted < MIN_P) data_d = MIN_P[DATA_WIDTH-1:0];
    else                      data_d = shifted[DATA_WIDTH-1:0];
  end

  // The tick-cycle step is folded into the closing window via acc_sat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gate_q     <= '0;
      acc_q      <= '0;
      prod_q     <= '0;
      v1_q       <= 1'b0;
      rpm_ready  <= 1'b0;
      rpm_data_o <= '0;
      illegal_o  <= 1'b0;
    end else begin
      illegal_o <= illegal_d;
      v1_q      <= tick;
      rpm_ready <= v1_q;
      if (tick) begin
        gate_q <= '0;
        acc_q  <= '0;
        prod_q <= $signed({{DATA_WIDTH{acc_sat[DATA_WIDTH-1]}}, acc_sat}) * MUL_P;
      end else begin
        gate_q <= gate_q + 1'b1;
        acc_q  <= acc_sat;
      end
      if (v1_q) rpm_data_o <= data_d;
    end
  end

endmodule
